// File: rtl/lzw_pkg.sv
// Shared types and constants for the LZW encoder: FSM states, token packing, defaults.
package lzw_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_MISS,
    S_EMIT,
    S_LASTCHK,
    S_FLUSH
  } state_t;

  localparam logic [7:0] LIT_HI  = 8'h00;
  localparam logic [7:0] CODE_LO = 8'h00;

  localparam int DEF_DICT_DEPTH = 80;
  localparam int DEF_MAX_STR    = 16;

  function automatic logic [15:0] lit_token(input logic [7:0] b);
    return {LIT_HI, b};
  endfunction

  function automatic logic [15:0] code_token(input logic [7:0] c);
    return {c, CODE_LO};
  endfunction

endpackage

// File: rtl/lzw_dict_mem.sv
// Dictionary storage: string/length registers, one write port at `count`,
// and a single compare of entry[index] against the candidate string.
module lzw_dict_mem
  import lzw_pkg::*;
#(
  parameter int DICT_DEPTH = DEF_DICT_DEPTH,
  parameter int MAX_STR    = DEF_MAX_STR,
  parameter int IW         = $clog2(DICT_DEPTH + 1),
  parameter int LW         = $clog2(MAX_STR + 2)
) (
  input  logic                    i_clk,
  input  logic [IW-1:0]           index,
  input  logic [MAX_STR-1:0][7:0] pc_vec,
  input  logic [LW-1:0]           pc_len,
  input  logic                    wr_en,
  input  logic [IW-1:0]           count,
  output logic                    hit
);

  logic [MAX_STR-1:0][7:0] str_mem [DICT_DEPTH];
  logic [LW-1:0]           len_mem [DICT_DEPTH];
  logic [MAX_STR-1:0][7:0] rd_str;
  logic [LW-1:0]           rd_len;

  always_ff @(posedge i_clk) begin
    for (int e = 0; e < DICT_DEPTH; e++) begin
      if (wr_en && count == IW'(e)) begin
        str_mem[e] <= pc_vec;
        len_mem[e] <= pc_len;
      end
    end
  end

  always_comb begin
    rd_str = '0;
    rd_len = '0;
    for (int e = 0; e < DICT_DEPTH; e++) begin
      if (index == IW'(e)) begin
        rd_str = str_mem[e];
        rd_len = len_mem[e];
      end
    end
  end

  // Bytes past the string length are always stored and presented as zero,
  // so a full-width compare equals a length-limited one.
  assign hit = (rd_len == pc_len) && (rd_str == pc_vec);

endmodule

// File: rtl/lzw_encode.sv
// Streaming LZW encoder with a sequentially searched register dictionary.
// Define LZW_DICT_RESET_EN to clear the dictionary after every packet.
module lzw_encode
  import lzw_pkg::*;
#(
  parameter int DICT_DEPTH = DEF_DICT_DEPTH,
  parameter int MAX_STR    = DEF_MAX_STR
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_axis_data,
  input  logic        i_axis_valid,
  input  logic        i_axis_last,
  output logic        o_axis_ready,
  output logic [15:0] o_token_data,
  output logic        o_token_valid,
  output logic        o_token_last,
  input  logic        i_token_ready,
  output logic        o_dict_full
);

  localparam int IW = $clog2(DICT_DEPTH + 1);
  localparam int LW = $clog2(MAX_STR + 2);

  state_t                  state, state_nx;
  logic [MAX_STR-1:0][7:0] p_buf, pc_vec;
  logic [LW-1:0]           p_len, pc_len;
  logic [7:0]              p_code, c_reg;
  logic                    last_reg;
  logic [IW-1:0]           idx, count;
  logic                    hit, skip, search_hit, search_end, can_write, tok_acc;
  logic [15:0]             p_token;
  logic                    latch, scan, grow, miss, final_ld, emit_done, flush_done;

  // P+C: the new byte lands right after the current string, rest stays zero.
  always_comb begin
    pc_vec = p_buf;
    for (int b = 0; b < MAX_STR; b++)
      if (p_len == LW'(b)) pc_vec[b] = c_reg;
  end

  assign pc_len     = p_len + LW'(1);
  assign skip       = (p_len >= LW'(MAX_STR)) || (count == '0);
  assign search_hit = !skip && hit;
  assign search_end = skip || (idx + IW'(1) == count);
  assign can_write  = (count < IW'(DICT_DEPTH)) && (p_len < LW'(MAX_STR));
  assign p_token    = (p_len == LW'(1)) ? lit_token(p_buf[0]) : code_token(p_code);
  assign tok_acc    = o_token_valid && i_token_ready;
  assign o_dict_full = (count == IW'(DICT_DEPTH));

  lzw_dict_mem #(
    .DICT_DEPTH(DICT_DEPTH),
    .MAX_STR   (MAX_STR),
    .IW        (IW),
    .LW        (LW)
  ) u_dict (
    .i_clk (i_clk),
    .index (idx),
    .pc_vec(pc_vec),
    .pc_len(pc_len),
    .wr_en (miss && can_write),
    .count (count),
    .hit   (hit)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (i_axis_valid) state_nx = (p_len == '0) ? S_LASTCHK : S_SEARCH;
      S_SEARCH:  if (search_hit) state_nx = S_LASTCHK;
                 else if (search_end) state_nx = S_MISS;
      S_MISS:    state_nx = S_EMIT;
      S_EMIT:    if (tok_acc) state_nx = S_LASTCHK;
      S_LASTCHK: state_nx = last_reg ? S_FLUSH : S_IDLE;
      S_FLUSH:   if (tok_acc) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    o_axis_ready = 1'b0;
    latch        = 1'b0;
    scan         = 1'b0;
    grow         = 1'b0;
    miss         = 1'b0;
    final_ld     = 1'b0;
    emit_done    = 1'b0;
    flush_done   = 1'b0;
    case (state)
      S_IDLE:    begin o_axis_ready = 1'b1; latch = i_axis_valid; end
      S_SEARCH:  begin grow = search_hit; scan = !search_hit; end
      S_MISS:    miss = 1'b1;
      S_EMIT:    emit_done = tok_acc;
      S_LASTCHK: final_ld = last_reg;
      S_FLUSH:   flush_done = tok_acc;
      default:   ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      p_buf         <= '0;
      p_len         <= '0;
      p_code        <= '0;
      c_reg         <= '0;
      last_reg      <= 1'b0;
      idx           <= '0;
      count         <= '0;
      o_token_data  <= '0;
      o_token_valid <= 1'b0;
      o_token_last  <= 1'b0;
    end else begin
      if (latch) begin
        c_reg    <= i_axis_data;
        last_reg <= i_axis_last;
        idx      <= '0;
        if (p_len == '0) begin
          p_buf    <= '0;
          p_buf[0] <= i_axis_data;
          p_len    <= LW'(1);
        end
      end
      if (scan) idx <= idx + IW'(1);
      if (grow) begin
        p_buf  <= pc_vec;
        p_len  <= pc_len;
        p_code <= 8'(idx) + 8'd1;
      end
      if (miss) begin
        o_token_data  <= p_token;
        o_token_valid <= 1'b1;
        o_token_last  <= 1'b0;
        if (can_write) count <= count + IW'(1);
        p_buf    <= '0;
        p_buf[0] <= c_reg;
        p_len    <= LW'(1);
      end
      if (emit_done) o_token_valid <= 1'b0;
      if (final_ld) begin
        o_token_data  <= p_token;
        o_token_valid <= 1'b1;
        o_token_last  <= 1'b1;
      end
      if (flush_done) begin
        o_token_valid <= 1'b0;
        o_token_last  <= 1'b0;
        p_len         <= '0;
`ifdef LZW_DICT_RESET_EN
        count         <= '0;
`else
        count         <= count;
`endif
      end
    end
  end

endmodule

// File: tb/tb_lzw_encode.sv
// Bench for lzw_encode: three parameterizations, directed vectors plus random
// packets checked against a string-keyed LZW reference model.
module tb_lzw_encode;

  typedef logic [7:0]  bq_t[$];
  typedef logic [16:0] tq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ad[3];
  logic        av[3], al[3], ar[3], tv[3], tl[3], tr[3], df[3];
  logic [15:0] td[3];

  int  tests = 0, fails = 0, cur = 0;
  tq_t got;
  int  m_dict[string];
  int  m_count, m_depth, m_maxs;

  always #5 clk = ~clk;

  lzw_encode u_main (
    .i_clk(clk), .i_rst(rst), .i_axis_data(ad[0]), .i_axis_valid(av[0]), .i_axis_last(al[0]),
    .o_axis_ready(ar[0]), .o_token_data(td[0]), .o_token_valid(tv[0]), .o_token_last(tl[0]),
    .i_token_ready(tr[0]), .o_dict_full(df[0]));

  lzw_encode #(.MAX_STR(2)) u_ms2 (
    .i_clk(clk), .i_rst(rst), .i_axis_data(ad[1]), .i_axis_valid(av[1]), .i_axis_last(al[1]),
    .o_axis_ready(ar[1]), .o_token_data(td[1]), .o_token_valid(tv[1]), .o_token_last(tl[1]),
    .i_token_ready(tr[1]), .o_dict_full(df[1]));

  lzw_encode #(.DICT_DEPTH(2)) u_dd2 (
    .i_clk(clk), .i_rst(rst), .i_axis_data(ad[2]), .i_axis_valid(av[2]), .i_axis_last(al[2]),
    .o_axis_ready(ar[2]), .o_token_data(td[2]), .o_token_valid(tv[2]), .o_token_last(tl[2]),
    .i_token_ready(tr[2]), .o_dict_full(df[2]));

  always @(negedge clk)
    if (!rst && tv[cur] && tr[cur]) got.push_back({tl[cur], td[cur]});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] mtok(input int plen, input logic [7:0] pbyte, input int pcode);
    return (plen == 1) ? {8'h00, pbyte} : {pcode[7:0], 8'h00};
  endfunction

  task automatic model_reset(input int depth, input int maxs);
    m_dict.delete();
    m_count = 0;
    m_depth = depth;
    m_maxs  = maxs;
  endtask

  // Textbook LZW over hex-string keys with the block's length and size limits.
  task automatic model_packet(input bq_t b, output tq_t t);
    string p, pc;
    int plen, pcode;
    logic [7:0] pbyte;
    t.delete();
    p = ""; plen = 0; pcode = 0; pbyte = 8'h00;
    foreach (b[i]) begin
      pc = {p, $sformatf("%02x", b[i])};
      if (plen == 0) begin
        p = pc; plen = 1; pbyte = b[i];
      end else if (plen + 1 <= m_maxs && m_dict.exists(pc)) begin
        p = pc; plen++; pcode = m_dict[pc];
      end else begin
        t.push_back({1'b0, mtok(plen, pbyte, pcode)});
        if (m_count < m_depth && plen + 1 <= m_maxs) begin
          m_count++;
          m_dict[pc] = m_count;
        end
        p = $sformatf("%02x", b[i]); plen = 1; pbyte = b[i];
      end
    end
    t.push_back({1'b1, mtok(plen, pbyte, pcode)});
`ifdef LZW_DICT_RESET_EN
    m_dict.delete();
    m_count = 0;
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input logic lst);
    int n = 0;
    ad[cur] = b; al[cur] = lst; av[cur] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!ar[cur] && n < 300);
    if (!ar[cur]) chk("axis_ready_timeout", ar[cur], 1);
    step();
    av[cur] = 1'b0; al[cur] = 1'b0;
  endtask

  task automatic run_packet(input string name, input bq_t b, input tq_t exp, input bit stall);
    int n;
    bit stalled = 0, done;
    logic [15:0] snap;
    got.delete();
    if (stall) tr[cur] = 1'b0;
    foreach (b[i]) begin
      send_byte(b[i], i == b.size() - 1);
      if (stall && !stalled) begin
        n = 0;
        while (!tv[cur] && n < 40) begin @(negedge clk); n++; end
        if (tv[cur]) begin
          snap = td[cur];
          repeat (10) begin
            @(negedge clk);
            chk("stall_data", td[cur], snap);
            chk("stall_valid", tv[cur], 1);
            chk("stall_axis_ready", ar[cur], 0);
          end
          stalled = 1;
        end
        step();
        if (stalled) tr[cur] = 1'b1;
      end
    end
    if (stall) chk("stall_seen", stalled, 1);
    n = 0;
    done = 0;
    while (!done && n < 600) begin
      @(negedge clk);
      n++;
      done = (got.size() > 0) && got[got.size()-1][16];
    end
    chk({name, "_last_seen"}, done, 1);
    step();
    step();
    chk({name, "_count"}, got.size(), exp.size());
    foreach (exp[i])
      chk($sformatf("%s_tok%0d", name, i), (i < got.size()) ? got[i] : 17'h1ffff, exp[i]);
  endtask

  task automatic chk_reset(input int d);
    chk($sformatf("rst%0d_axis_ready", d), ar[d], 1);
    chk($sformatf("rst%0d_data", d), td[d], 0);
    chk($sformatf("rst%0d_valid", d), tv[d], 0);
    chk($sformatf("rst%0d_last", d), tl[d], 0);
    chk($sformatf("rst%0d_full", d), df[d], 0);
  endtask

  initial begin
    bq_t b, v1;
    tq_t e, e2, v1_exp;
    int len;

    for (int i = 0; i < 3; i++) begin
      ad[i] = 8'h00; av[i] = 1'b0; al[i] = 1'b0; tr[i] = 1'b1;
    end
    v1     = {8'h41, 8'h42, 8'h41, 8'h42, 8'h41, 8'h42, 8'h41};
    v1_exp = {17'h00041, 17'h00042, 17'h00100, 17'h10300};

    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) chk_reset(d);
    step();
    rst = 1'b0;
    step();

    // MAX_STR=2: the third A cannot extend "AA"
    cur = 1;
    model_reset(80, 2);
    b = {8'h41, 8'h41, 8'h41, 8'h41};
    model_packet(b, e);
    e2 = {17'h00041, 17'h00100, 17'h10041};
    run_packet("ms2", b, e2, 0);

    // DICT_DEPTH=2: fills after two misses, then literals only
    cur = 2;
    model_reset(2, 16);
    b = {8'h41, 8'h42, 8'h43, 8'h44};
    model_packet(b, e);
    e2 = {17'h00041, 17'h00042, 17'h00043, 17'h10044};
    run_packet("dd2", b, e2, 0);
    chk("dd2_full", df[2], (m_count == m_depth) ? 1 : 0);
    b = {8'h41, 8'h42};
    model_packet(b, e);
    run_packet("dd2_b", b, e, 0);
    chk("dd2_b_full", df[2], (m_count == m_depth) ? 1 : 0);

    cur = 0;
    model_reset(80, 16);
    model_packet(v1, e);
    run_packet("v1", v1, v1_exp, 0);

    b = {8'h00};
    model_packet(b, e);
    e2 = {17'h10000};
    run_packet("zero", b, e2, 0);
    chk("zero_axis_ready", ar[0], 1);

    model_packet(v1, e);
    run_packet("stall", v1, e, 1);

    for (int k = 0; k < 8; k++) begin
      b.delete();
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++)
        b.push_back(($urandom_range(0, 9) < 8) ? 8'(8'h41 + $urandom_range(0, 2))
                                              : 8'($urandom_range(0, 255)));
      model_packet(b, e);
      run_packet($sformatf("rand%0d", k), b, e, 0);
    end

    // Reset while the second byte is being searched
    got.delete();
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset(0);
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_no_token", got.size(), 0);
    model_reset(80, 16);

    model_packet(v1, e);
    run_packet("v1_rerun", v1, v1_exp, 0);
    model_packet(v1, e);
    run_packet("v1_repeat", v1, e, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
